uart_loopback_ctrl: RTL and testbench
=====================================

UART_LOOPBACK_CTRL -- requirements
Module: uart_loopback_ctrl

Interface
REQ-001 Parameters SHALL be exactly these (name, default, meaning):
  DEPTH, 16, byte-buffer entries (power of two, 2..64)
  GAP_CYCLES, 21810, idle clocks inserted after each transmitted byte (one bit time)
REQ-002 Ports SHALL be exactly these (name direction width meaning):
  clk  input  1  single clock; all state changes on rising edge
  i_reset  input  1  synchronous active-high reset, acts on the edge where it is sampled high
  i_rx_data  input  8  received byte, valid only with i_rx_valid
  i_rx_valid  input  1  one-cycle pulse: byte available from receiver
  i_tx_busy  input  1  transmitter busy (high from accept of a start until stop bit done)
  o_tx_data  output  8  byte to transmit, valid while o_tx_start high
  o_tx_start  output  1  one-cycle transmit request
  o_overflow  output  1  sticky: a byte was dropped because buffer was full
  o_drop_count  output  8  saturating count of dropped bytes
  o_debug  output  8  buffer occupancy, zero-extended

Function
REQ-003 Buffer SHALL be a FIFO of DEPTH bytes with occupancy count 0..DEPTH; read/write pointers wrap modulo DEPTH.
REQ-004 On an edge with i_rx_valid=1 and count<DEPTH, i_rx_data SHALL be written at the write pointer and the count incremented.
REQ-005 On i_rx_valid=1 with count==DEPTH and no pop on that edge, the byte SHALL be discarded, o_overflow set to 1, o_drop_count incremented, saturating at 255.
REQ-006 Simultaneous push and pop on the same edge SHALL both complete: count unchanged, even when full; no drop occurs.
REQ-007 Controller FSM SHALL have states IDLE, START, WAIT_ACCEPT, WAIT_DONE, GAP.
REQ-008 IDLE: if count>0 and i_tx_busy=0, SHALL go to START; otherwise remain.
REQ-009 START (exactly one cycle): o_tx_start=1, o_tx_data=FIFO head; the FIFO SHALL pop on the edge leaving START; next state WAIT_ACCEPT.
REQ-010 WAIT_ACCEPT: SHALL go to WAIT_DONE when i_tx_busy=1; when i_tx_busy=0 for 4 consecutive cycles, SHALL go to GAP (byte counted as sent; no retry).
REQ-011 WAIT_DONE: SHALL go to GAP when i_tx_busy=0.
REQ-012 GAP: cycle counter SHALL run from 1 to GAP_CYCLES, then return to IDLE with counter cleared; counter width SHALL be clog2(GAP_CYCLES+1).
REQ-013 Latency: i_rx_valid sampled high at edge N with buffer empty, FSM in IDLE, i_tx_busy=0 SHALL give o_tx_start=1 in the cycle after edge N+1.
REQ-014 Outside START, o_tx_start SHALL be 0 and o_tx_data SHALL be 0.
REQ-015 Bytes SHALL be transmitted in arrival order; no byte is sent twice.

Reset
REQ-016 On an edge with i_reset=1, the controller SHALL set: FSM IDLE, pointers/count 0, gap and accept counters 0, o_overflow 0, o_drop_count 0; FIFO storage is not cleared.
REQ-017 Reset mid-transfer (any state) SHALL abandon the in-flight byte and all buffered bytes; i_rx_valid on a reset edge SHALL be ignored.
REQ-018 All outputs SHALL read 0 in the cycle after a reset edge.

Structure
REQ-019 State enum (IDLE..GAP) and the default timing constants (FULL_BIT 21810, HALF_BIT 10905) SHALL live in shared package uart_pkg, which the receiver also uses.
REQ-020 The FIFO SHALL be sub-module uart_byte_fifo (push, pop, data in/out, count, full, empty); the FSM, counters and drop logic stay in uart_loopback_ctrl.

Verification (GAP_CYCLES=8, DEPTH=4 in bench)
REQ-021 Single byte 0xA5, tx_busy model accepts 1 cycle after start, busy 10 cycles -> o_tx_start one cycle carrying 0xA5 at the REQ-013 time; next start no earlier than 8 cycles after busy falls.
REQ-022 Burst 0x01..0x06 back-to-back while i_tx_busy held 1 -> o_debug reaches 4, o_overflow=1, o_drop_count=2; after release, 0x01..0x04 transmitted in order.
REQ-023 Full buffer, push 0x77 on the pop edge -> o_drop_count unchanged, 0x77 later transmitted last.
REQ-024 Transmitter never raises busy -> start, 4 cycles WAIT_ACCEPT, GAP, next byte started; no hang.
REQ-025 i_reset pulsed in WAIT_DONE with 3 bytes buffered -> next cycle all outputs 0, o_debug=0; no further o_tx_start until a new i_rx_valid.
REQ-026 i_rx_valid coincident with i_reset -> byte not stored, o_debug stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: loopback controller states and bit timing.
// Also imported by the receiver for its bit-period constants.
package uart_pkg;

    // Loopback controller states
    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_ACCEPT,
        WAIT_DONE,
        GAP
    } ctrl_state_e;

    // Default bit timing in clock cycles
    localparam int unsigned FULL_BIT = 21810;
    localparam int unsigned HALF_BIT = 10905;

    // Idle-busy cycles before a start is treated as accepted anyway
    localparam int unsigned ACCEPT_TIMEOUT = 4;

    // Occupancy counter width for a buffer of 'depth' entries (0..depth)
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_loopback_ctrl_if.sv
// Byte FIFO access bundle between the loopback controller and its buffer.
// master: push/pop/wdata out, rdata/count/full/empty in; slave: mirrored.
interface uart_loopback_ctrl_if
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
);

    localparam int CW = cnt_width(DEPTH);

    logic          push;
    logic          pop;
    logic [7:0]    wdata;
    logic [7:0]    rdata;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    modport master (
        output push, pop, wdata,
        input  rdata, count, full, empty
    );

    modport slave (
        input  push, pop, wdata,
        output rdata, count, full, empty
    );

endinterface

// File: rtl/uart_byte_fifo.sv
// Circular byte buffer of DEPTH entries with occupancy count 0..DEPTH.
// Ports: clk, i_reset (sync, active high), fif (slave side of the bundle).
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  i_reset,
    uart_loopback_ctrl_if.slave   fif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_pop   = fif.pop && (count_q != '0) && !i_reset;
        // A push into a full buffer is fine when the head leaves on the same edge
        do_push  = fif.push && !i_reset
                   && ((count_q != FULL_CNT) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left untouched by reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= fif.wdata;
        end
    end

    assign fif.rdata = mem_q[rd_ptr_q];
    assign fif.count = count_q;
    assign fif.full  = (count_q == FULL_CNT);
    assign fif.empty = (count_q == '0);

endmodule

// File: rtl/uart_loopback_ctrl.sv
// Loopback controller: buffers received bytes and replays them to the UART
// transmitter one at a time, with a one-bit idle gap after each byte.
// Ports: clk, i_reset (sync, active high); i_rx_data/i_rx_valid from the
// receiver; i_tx_busy from the transmitter; o_tx_data/o_tx_start to the
// transmitter; o_overflow (sticky), o_drop_count (saturating), o_debug
// (buffer occupancy).
module uart_loopback_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = FULL_BIT
) (
    input  logic       clk,
    input  logic       i_reset,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    input  logic       i_tx_busy,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    output logic       o_overflow,
    output logic [7:0] o_drop_count,
    output logic [7:0] o_debug
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);
    localparam logic [1:0]    ACC_LAST = 2'(ACCEPT_TIMEOUT - 1);

    uart_loopback_ctrl_if #(.DEPTH(DEPTH)) fifo_bus ();

    uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .i_reset (i_reset),
        .fif     (fifo_bus.slave)
    );

    ctrl_state_e   state_q, state_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [1:0]    acc_cnt_q, acc_cnt_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_q, drop_d;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          pop;
    logic          drop;

    // Controller FSM: next state, counters and transmit request
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        acc_cnt_d = acc_cnt_q;
        tx_start  = 1'b0;
        tx_data   = 8'h00;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_bus.empty && !i_tx_busy) begin
                    state_d = START;
                end
            end
            START: begin
                tx_start  = 1'b1;
                tx_data   = fifo_bus.rdata;
                pop       = 1'b1;
                acc_cnt_d = '0;
                state_d   = WAIT_ACCEPT;
            end
            WAIT_ACCEPT: begin
                if (i_tx_busy) begin
                    acc_cnt_d = '0;
                    state_d   = WAIT_DONE;
                end else if (acc_cnt_q == ACC_LAST) begin
                    // Never accepted: give the byte up rather than retry
                    acc_cnt_d = '0;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end else begin
                    acc_cnt_d = acc_cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy) begin
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Receive side: store or drop, overflow bookkeeping
    always_comb begin
        fifo_bus.push  = i_rx_valid && !i_reset
                         && (!fifo_bus.full || pop);
        fifo_bus.pop   = pop;
        fifo_bus.wdata = i_rx_data;
        drop           = i_rx_valid && !i_reset
                         && fifo_bus.full && !pop;
        overflow_d     = overflow_q | drop;
        drop_d         = drop_q;
        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            gap_cnt_q  <= '0;
            acc_cnt_q  <= '0;
            overflow_q <= 1'b0;
            drop_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            acc_cnt_q  <= acc_cnt_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign o_tx_start   = tx_start;
    assign o_tx_data    = tx_data;
    assign o_overflow   = overflow_q;
    assign o_drop_count = drop_q;
    assign o_debug      = 8'(fifo_bus.count);

endmodule

// File: tb/tb_uart_loopback_ctrl.sv
// Scoreboard bench for uart_loopback_ctrl (DEPTH=4, GAP_CYCLES=8).
// Inputs change on falling edges; outputs are compared on falling edges.
module tb_uart_loopback_ctrl;

    localparam int DEPTH    = 4;
    localparam int GAP      = 8;
    localparam int BUSY_LEN = 10;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_valid = 1'b0;
    logic       i_tx_busy = 1'b0;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_overflow;
    logic [7:0] o_drop_count;
    logic [7:0] o_debug;

    always #5 clk = ~clk;

    uart_loopback_ctrl #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .i_tx_busy    (i_tx_busy),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .o_overflow   (o_overflow),
        .o_drop_count (o_drop_count),
        .o_debug      (o_debug)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: buffered bytes in arrival order
    logic [7:0] sb_q[$];
    logic [7:0] sent_log[$];
    bit         exp_ovf = 1'b0;
    int         exp_drop = 0;
    int         cyc = 0;
    int         start_cnt = 0;
    int         last_fall = -1;
    int         prev_start = -1;
    bit         hold_busy = 1'b0;
    bit         never_acc = 1'b0;
    int         acc_wait = 0;
    int         busy_left = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (i_reset) begin
            sb_q.delete();
            exp_ovf  <= 1'b0;
            exp_drop <= 0;
        end else begin
            if (i_rx_valid) begin
                if (sb_q.size() < DEPTH || o_tx_start) begin
                    sb_q.push_back(i_rx_data);
                end else begin
                    exp_ovf <= 1'b1;
                    if (exp_drop < 255) exp_drop <= exp_drop + 1;
                end
            end
            if (o_tx_start && sb_q.size() > 0) void'(sb_q.pop_front());
        end
    end

    // Monitor: compare what the DUT presents against the model
    always @(negedge clk) begin
        chk("debug", int'(o_debug), sb_q.size());
        chk("overflow", int'(o_overflow), int'(exp_ovf));
        chk("drop_count", int'(o_drop_count), exp_drop);
        if (o_tx_start) begin
            start_cnt++;
            chk("start_has_data", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) chk("tx_data", int'(o_tx_data), int'(sb_q[0]));
            sent_log.push_back(o_tx_data);
            if (last_fall >= 0) begin
                chk("gap_after_busy", int'((cyc - last_fall) >= GAP), 1);
                last_fall = -1;
            end
            if (never_acc && prev_start >= 0) begin
                chk("timeout_interval",
                    int'((cyc - prev_start) >= 1 + 4 + GAP
                         && (cyc - prev_start) <= 1 + 4 + GAP + 3), 1);
            end
            prev_start = cyc;
        end else begin
            chk("tx_data_idle", int'(o_tx_data), 0);
        end
    end

    // Transmitter model: busy one cycle after start, for BUSY_LEN cycles
    always @(negedge clk) begin
        if (hold_busy) begin
            i_tx_busy = 1'b1;
        end else if (acc_wait > 0) begin
            acc_wait--;
            if (acc_wait == 0) begin
                i_tx_busy = 1'b1;
                busy_left = BUSY_LEN;
            end
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                i_tx_busy = 1'b0;
                last_fall = cyc;
            end
        end else begin
            i_tx_busy = 1'b0;
        end
        if (o_tx_start && !never_acc && !hold_busy) acc_wait = 1;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic burst(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_rx_valid = 1'b1;
            i_rx_data  = first + 8'(i);
        end
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        chk("rst_tx_start", int'(o_tx_start), 0);
        chk("rst_tx_data", int'(o_tx_data), 0);
        chk("rst_overflow", int'(o_overflow), 0);
        chk("rst_drop", int'(o_drop_count), 0);
        chk("rst_debug", int'(o_debug), 0);
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) chk("drain_timeout", sb_q.size(), 0);
        idle(40);
    endtask

    task automatic check_sent(input string name, input int base,
                              input logic [7:0] exp_b[$]);
        chk({name, "_count"}, sent_log.size() - base, exp_b.size());
        for (int i = 0; i < exp_b.size(); i++) begin
            if (base + i < sent_log.size())
                chk(name, int'(sent_log[base + i]), int'(exp_b[i]));
        end
    endtask

    initial begin
        int base;
        int sc;
        bit seen;
        logic [7:0] exp_b[$];

        idle(2);
        do_reset();

        // Single byte: latency and gap before the next start
        @(negedge clk);
        i_rx_valid = 1'b1;
        i_rx_data  = 8'hA5;
        @(negedge clk);
        i_rx_valid = 1'b0;
        chk("latency_early", int'(o_tx_start), 0);
        @(negedge clk);
        chk("latency_start", int'(o_tx_start), 1);
        chk("latency_data", int'(o_tx_data), 8'hA5);
        send(8'h5A);
        drain();

        // Burst into a held transmitter: overflow and drops
        do_reset();
        base = sent_log.size();
        hold_busy = 1'b1;
        idle(2);
        burst(8'h01, 6);
        chk("burst_debug", int'(o_debug), 4);
        chk("burst_overflow", int'(o_overflow), 1);
        chk("burst_drop", int'(o_drop_count), 2);
        hold_busy = 1'b0;
        drain();
        exp_b = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_sent("burst_order", base, exp_b);

        // Full buffer, push on the pop edge
        do_reset();
        base = sent_log.size();
        hold_busy = 1'b1;
        idle(2);
        burst(8'h10, 4);
        chk("full_debug", int'(o_debug), 4);
        hold_busy = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = o_tx_start;
        end
        chk("full_start_seen", int'(seen), 1);
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h77;
        @(negedge clk);
        i_rx_valid = 1'b0;
        chk("pop_push_drop", int'(o_drop_count), 0);
        chk("pop_push_debug", int'(o_debug), 4);
        drain();
        exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h77};
        check_sent("pop_push_order", base, exp_b);

        // Transmitter never accepts: timeout path, no hang
        never_acc  = 1'b1;
        prev_start = -1;
        base = sent_log.size();
        send(8'h31);
        send(8'h32);
        send(8'h33);
        drain();
        exp_b = '{8'h31, 8'h32, 8'h33};
        check_sent("timeout_order", base, exp_b);
        never_acc  = 1'b0;
        prev_start = -1;

        // Reset while waiting for the transmitter with 3 bytes buffered
        burst(8'h41, 4);
        idle(1);
        chk("pre_reset_debug", int'(o_debug), 3);
        do_reset();
        sc = start_cnt;
        idle(40);
        chk("no_start_after_reset", start_cnt, sc);

        // Receive coincident with reset is ignored
        @(negedge clk);
        i_reset    = 1'b1;
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h3C;
        @(negedge clk);
        i_reset    = 1'b0;
        i_rx_valid = 1'b0;
        chk("rx_on_reset_debug", int'(o_debug), 0);
        sc = start_cnt;
        idle(20);
        chk("rx_on_reset_no_start", start_cnt, sc);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            i_rx_valid = ($urandom_range(0, 3) == 0);
            i_rx_data  = 8'($urandom);
        end
        @(negedge clk);
        i_rx_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
